pipe_stall_ctrl: RTL and testbench

- Central pipeline controller for the six-stage core: PC, IF, ID, EX, MEM and WB.
- Merges stall requests from IF, ID, EX and MEM into the stall[5:0] vector consumed by every pipeline register, including EX/MEM.
- Converts committed exceptions into a flush pulse plus a redirect PC.
- Tracks stall duration: a watchdog flag plus saturating performance counters, readable by the debug/CP0 side.

---
 rtl/pipe_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline controller: merges stage stall requests, turns committed
// exceptions into flush + redirect, and tracks stall duration for debug/CP0.
module pipe_stall_ctrl #(
    parameter int          WDOG_LIMIT = 1024,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] INT_VECTOR = 32'h00000020,
    parameter logic [31:0] EXC_VECTOR = 32'h00000040
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if_i,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             stallreq_mem_i,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             cnt_clr_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o,
    output logic             stall_timeout_o
);

    localparam int RL_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [RL_W-1:0] RL_MAX = RL_W'(WDOG_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RL_W-1:0]  run_len_q, run_len_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             stall_timeout_q, stall_timeout_d;

    logic exc_present;
    logic stalling;

    // Pipeline control is combinational so every register acts on the same edge.
    always_comb begin
        exc_present = |excepttype_i;
        stall_o     = 6'b000000;
        flush_o     = 1'b0;
        new_pc_o    = 32'h0;
        if (exc_present) begin
            flush_o = 1'b1;
            case (excepttype_i)
                32'h1:                               new_pc_o = INT_VECTOR;
                32'h8, 32'h9, 32'ha, 32'hc, 32'hd:   new_pc_o = EXC_VECTOR;
                32'he:                               new_pc_o = cp0_epc_i;
                default:                             new_pc_o = EXC_VECTOR;
            endcase
        end else if (stallreq_mem_i) begin
            stall_o = 6'b011111;
        end else if (stallreq_ex_i) begin
            stall_o = 6'b001111;
        end else if (stallreq_id_i) begin
            stall_o = 6'b000111;
        end else if (stallreq_if_i) begin
            stall_o = 6'b000011;
        end
        stalling = |stall_o;
    end

    always_comb begin
        state_d = ST_RUN;
        if (exc_present) begin
            state_d = ST_FLUSH;
        end else if (stalling) begin
            state_d = ST_STALL;
        end

        run_len_d = run_len_q;
        if (!stalling) begin
            run_len_d = '0;
        end else if (run_len_q != RL_MAX) begin
            run_len_d = run_len_q + RL_W'(1);
        end

        // A clear wins over any increment or watchdog trip on the same edge.
        stall_timeout_d = stall_timeout_q;
        stall_cycles_d  = stall_cycles_q;
        flush_count_d   = flush_count_q;
        if (cnt_clr_i) begin
            stall_timeout_d = 1'b0;
            stall_cycles_d  = '0;
            flush_count_d   = '0;
        end else begin
            if (stalling && run_len_d == RL_MAX) begin
                stall_timeout_d = 1'b1;
            end
            if (stalling && stall_cycles_q != {CNT_W{1'b1}}) begin
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
            end
            if (flush_o && flush_count_q != {CNT_W{1'b1}}) begin
                flush_count_d = flush_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_RUN;
            run_len_q       <= '0;
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            run_len_q       <= run_len_d;
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign state_o         = state_q;
    assign stall_cycles_o  = stall_cycles_q;
    assign flush_count_o   = flush_count_q;
    assign stall_timeout_o = stall_timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic        cnt_clr_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [1:0]  state_o;
    logic [31:0] stall_cycles_o, flush_count_o;
    logic        stall_timeout_o;

    typedef struct {
        int          step;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [1:0]  state;
        logic [31:0] sc;
        logic [31:0] fc;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   compare_count  = 0;
    int   mismatch_count = 0;
    int   step_num       = 0;

    pipe_stall_ctrl #(
        .WDOG_LIMIT(4),
        .CNT_W(32),
        .INT_VECTOR(32'h00000020),
        .EXC_VECTOR(32'h00000040)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stallreq_if_i(stallreq_if_i),
        .stallreq_id_i(stallreq_id_i),
        .stallreq_ex_i(stallreq_ex_i),
        .stallreq_mem_i(stallreq_mem_i),
        .excepttype_i(excepttype_i),
        .cp0_epc_i(cp0_epc_i),
        .cnt_clr_i(cnt_clr_i),
        .stall_o(stall_o),
        .flush_o(flush_o),
        .new_pc_o(new_pc_o),
        .state_o(state_o),
        .stall_cycles_o(stall_cycles_o),
        .flush_count_o(flush_count_o),
        .stall_timeout_o(stall_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic checkField(input int step, input string name,
                              input logic [31:0] got, input logic [31:0] want);
        compare_count++;
        if (got !== want) begin
            mismatch_count++;
            $display("[TB] FAIL step %0d %s: got %h expected %h", step, name, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField(e.step, "stall_o", 32'(stall_o), 32'(e.stall));
        checkField(e.step, "flush_o", 32'(flush_o), 32'(e.flush));
        checkField(e.step, "new_pc_o", new_pc_o, e.pc);
        checkField(e.step, "state_o", 32'(state_o), 32'(e.state));
        checkField(e.step, "stall_cycles_o", stall_cycles_o, e.sc);
        checkField(e.step, "flush_count_o", flush_count_o, e.fc);
        checkField(e.step, "stall_timeout_o", 32'(stall_timeout_o), 32'(e.to));
    endtask

    // Registered outputs seen in a step reflect the previous step's inputs.
    task automatic applyStimulus(
        input logic s_if, input logic s_id, input logic s_ex, input logic s_mem,
        input logic [31:0] exc, input logic [31:0] epc, input logic clr, input logic r,
        input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
        input logic [1:0] e_state, input logic [31:0] e_sc, input logic [31:0] e_fc,
        input logic e_to);
        exp_t e;
        @(posedge clk);
        #1;
        stallreq_if_i  = s_if;
        stallreq_id_i  = s_id;
        stallreq_ex_i  = s_ex;
        stallreq_mem_i = s_mem;
        excepttype_i   = exc;
        cp0_epc_i      = epc;
        cnt_clr_i      = clr;
        rst            = r;
        step_num++;
        e.step  = step_num;
        e.stall = e_stall;
        e.flush = e_flush;
        e.pc    = e_pc;
        e.state = e_state;
        e.sc    = e_sc;
        e.fc    = e_fc;
        e.to    = e_to;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        stallreq_if_i = 1'b0; stallreq_id_i = 1'b0;
        stallreq_ex_i = 1'b0; stallreq_mem_i = 1'b0;
        excepttype_i = 32'h0; cp0_epc_i = 32'h0; cnt_clr_i = 1'b0;
        repeat (2) @(posedge clk);

        //             if id ex mem  exc         epc           clr rst  stall      fl pc            st sc  fc to
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        0, 0,  0, 0); // 1
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        0, 0,  0, 0); // 2
        applyStimulus(0, 0, 1, 0, 32'h0,    32'h0,         0, 0, 6'b001111, 0, 32'h0,        0, 0,  0, 0); // 3
        applyStimulus(0, 0, 1, 0, 32'h0,    32'h0,         0, 0, 6'b001111, 0, 32'h0,        1, 1,  0, 0); // 4
        applyStimulus(0, 0, 1, 0, 32'h0,    32'h0,         0, 0, 6'b001111, 0, 32'h0,        1, 2,  0, 0); // 5
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        1, 3,  0, 0); // 6
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        0, 3,  0, 0); // 7
        applyStimulus(0, 1, 0, 1, 32'h0,    32'h0,         0, 0, 6'b011111, 0, 32'h0,        0, 3,  0, 0); // 8
        applyStimulus(0, 1, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000111, 0, 32'h0,        1, 4,  0, 0); // 9
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        1, 5,  0, 0); // 10
        applyStimulus(0, 0, 0, 1, 32'hc,    32'h0,         0, 0, 6'b000000, 1, 32'h40,       0, 5,  0, 0); // 11
        applyStimulus(0, 0, 0, 0, 32'he,    32'hbfc00100,  0, 0, 6'b000000, 1, 32'hbfc00100, 2, 5,  1, 0); // 12
        applyStimulus(0, 0, 0, 0, 32'h1,    32'hbfc00100,  0, 0, 6'b000000, 1, 32'h20,       2, 5,  2, 0); // 13
        applyStimulus(1, 0, 0, 0, 32'h1234, 32'h0,         0, 0, 6'b000000, 1, 32'h40,       2, 5,  3, 0); // 14
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        2, 5,  4, 0); // 15
        applyStimulus(1, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000011, 0, 32'h0,        0, 5,  4, 0); // 16
        applyStimulus(1, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000011, 0, 32'h0,        1, 6,  4, 0); // 17
        applyStimulus(1, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000011, 0, 32'h0,        1, 7,  4, 0); // 18
        applyStimulus(1, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000011, 0, 32'h0,        1, 8,  4, 0); // 19
        applyStimulus(1, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000011, 0, 32'h0,        1, 9,  4, 1); // 20
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        1, 10, 4, 1); // 21
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        0, 10, 4, 1); // 22
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         1, 0, 6'b000000, 0, 32'h0,        0, 10, 4, 1); // 23
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        0, 0,  0, 0); // 24
        applyStimulus(1, 0, 0, 0, 32'h0,    32'h0,         1, 0, 6'b000011, 0, 32'h0,        0, 0,  0, 0); // 25
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        1, 0,  0, 0); // 26
        applyStimulus(0, 0, 0, 1, 32'h0,    32'h0,         0, 0, 6'b011111, 0, 32'h0,        0, 0,  0, 0); // 27
        applyStimulus(0, 0, 0, 1, 32'h0,    32'h0,         0, 1, 6'b011111, 0, 32'h0,        1, 1,  0, 0); // 28
        applyStimulus(0, 0, 0, 0, 32'h0,    32'h0,         0, 0, 6'b000000, 0, 32'h0,        0, 0,  0, 0); // 29

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            mismatch_count++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
